fft_magnitude_sequencer: RTL and testbench

Control sequencer that turns a completed FFT frame into a magnitude spectrum. It reads complex bins from the FFT result RAM and streams them into the 3-stage magnitude approximator. It writes each returned magnitude into the spectrum RAM and tracks the peak bin. It sits between the FFT core and the display/analysis logic, starting on a frame-ready pulse and reporting completion with a one-cycle done pulse.

---
 rtl/fft_magnitude_sequencer_if.sv | 42 ++++
 rtl/fft_magnitude_sequencer.sv | 135 +++++++++++++
 tb/tb_fft_magnitude_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_magnitude_sequencer_if.sv
// Bundle of the sequencer's control, FFT-RAM read, magnitude-unit and spectrum-RAM write
// signals. The master modport is the sequencer; the slave modport is its surroundings
// (frame source, RAMs and the magnitude approximator).
interface fft_magnitude_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH = 10
);
  // Control
  logic                    i_start;
  logic                    i_half_spectrum;
  logic                    i_pause;
  logic                    o_busy;
  logic                    o_done;
  // FFT result RAM read port
  logic                    o_fft_rd_en;
  logic [ADDR_WIDTH-1:0]   o_fft_rd_addr;
  logic [2*DATA_WIDTH-1:0] i_fft_rd_data;
  // Magnitude approximator
  logic                    o_mag_start;
  logic [2*DATA_WIDTH-1:0] o_mag_complex;
  logic [DATA_WIDTH-1:0]   i_mag_magnitude;
  logic                    i_mag_valid;
  // Spectrum RAM write port
  logic                    o_spec_wr_en;
  logic [ADDR_WIDTH-1:0]   o_spec_wr_addr;
  logic [DATA_WIDTH-1:0]   o_spec_wr_data;
  // Peak report
  logic [ADDR_WIDTH-1:0]   o_peak_bin;
  logic [DATA_WIDTH-1:0]   o_peak_mag;

  modport master (
    input  i_start, i_half_spectrum, i_pause, i_fft_rd_data, i_mag_magnitude, i_mag_valid,
    output o_busy, o_done, o_fft_rd_en, o_fft_rd_addr, o_mag_start, o_mag_complex,
           o_spec_wr_en, o_spec_wr_addr, o_spec_wr_data, o_peak_bin, o_peak_mag
  );

  modport slave (
    output i_start, i_half_spectrum, i_pause, i_fft_rd_data, i_mag_magnitude, i_mag_valid,
    input  o_busy, o_done, o_fft_rd_en, o_fft_rd_addr, o_mag_start, o_mag_complex,
           o_spec_wr_en, o_spec_wr_addr, o_spec_wr_data, o_peak_bin, o_peak_mag
  );
endinterface

// File: rtl/fft_magnitude_sequencer.sv
// Walks a finished FFT frame through the magnitude approximator: issues bin reads,
// forwards the RAM data as the magnitude operand, writes returned magnitudes to the
// spectrum RAM and keeps the running peak. Completion is counted in returned results,
// so the unit's latency never has to be known here.
module fft_magnitude_sequencer #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned N_POINTS    = 1024,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned MAG_LATENCY = 3
) (
  input logic                       clk,
  input logic                       reset,
  fft_magnitude_sequencer_if.master bus
);

  // One extra bit so a full-length bin count of N_POINTS fits.
  localparam int unsigned CntW = ADDR_WIDTH + 1;
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t FullCount = cnt_t'(N_POINTS);
  localparam cnt_t HalfCount = cnt_t'(N_POINTS / 2);

  if (N_POINTS < 8 || (1 << ADDR_WIDTH) != N_POINTS || MAG_LATENCY == 0) begin : gen_bad_cfg
    $error("fft_magnitude_sequencer: N_POINTS must be 2**ADDR_WIDTH, >= 8, latency >= 1");
  end

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  cnt_t                  count_q, count_d;    // bins in this frame
  cnt_t                  rd_cnt_q, rd_cnt_d;  // next bin to read
  cnt_t                  wr_cnt_q, wr_cnt_d;  // next bin to write back
  logic [ADDR_WIDTH-1:0] peak_bin_q, peak_bin_d;
  logic [DATA_WIDTH-1:0] peak_mag_q, peak_mag_d;
  logic                  mag_start_q;

  logic rd_en;
  logic wr_en;
  logic busy;
  logic done;

  // Sequencing, writeback counting and peak tracking.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    peak_bin_d = peak_bin_q;
    peak_mag_d = peak_mag_q;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    // Results are accepted in every active state; in idle they are stale and dropped.
    if (state_q != StIdle && bus.i_mag_valid) begin
      wr_en    = 1'b1;
      wr_cnt_d = wr_cnt_q + cnt_t'(1);
      // Strict compare so a tie keeps the earlier (lower) bin.
      if (bus.i_mag_magnitude > peak_mag_q) begin
        peak_mag_d = bus.i_mag_magnitude;
        peak_bin_d = wr_cnt_q[ADDR_WIDTH-1:0];
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          count_d    = bus.i_half_spectrum ? HalfCount : FullCount;
          rd_cnt_d   = '0;
          wr_cnt_d   = '0;
          peak_bin_d = '0;
          peak_mag_d = '0;
          state_d    = StRead;
        end
      end
      StRead: begin
        busy = 1'b1;
        if (!bus.i_pause) begin
          rd_en    = 1'b1;
          rd_cnt_d = rd_cnt_q + cnt_t'(1);
          if (rd_cnt_q == count_q - cnt_t'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        busy = 1'b1;
        // Look at the post-write count so done follows the last write directly.
        if (wr_cnt_d == count_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any frame in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      peak_bin_q  <= '0;
      peak_mag_q  <= '0;
      mag_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      peak_bin_q  <= peak_bin_d;
      peak_mag_q  <= peak_mag_d;
      mag_start_q <= rd_en;  // RAM data arrives one cycle after the read
    end
  end

  assign bus.o_busy         = busy;
  assign bus.o_done         = done;
  assign bus.o_fft_rd_en    = rd_en;
  assign bus.o_fft_rd_addr  = rd_cnt_q[ADDR_WIDTH-1:0];
  assign bus.o_mag_start    = mag_start_q;
  // Data paths are zeroed when not qualified so idle and reset outputs stay quiet.
  assign bus.o_mag_complex  = mag_start_q ? bus.i_fft_rd_data : '0;
  assign bus.o_spec_wr_en   = wr_en;
  assign bus.o_spec_wr_addr = wr_cnt_q[ADDR_WIDTH-1:0];
  assign bus.o_spec_wr_data = wr_en ? bus.i_mag_magnitude : '0;
  assign bus.o_peak_bin     = peak_bin_q;
  assign bus.o_peak_mag     = peak_mag_q;

endmodule

// File: tb/tb_fft_magnitude_sequencer.sv
// Bench for fft_magnitude_sequencer: behavioural FFT RAM and latency-3 magnitude unit,
// a scoreboard of expected spectrum writes filled at frame start, and one task per
// scenario checking timing, read order, operands, writes and the peak report.
module tb_fft_magnitude_sequencer;
  localparam int unsigned DW         = 24;
  localparam int unsigned NP         = 8;
  localparam int unsigned AW         = 3;
  localparam int unsigned MagLatency = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fft_magnitude_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fft_magnitude_sequencer #(
    .DATA_WIDTH (DW),
    .N_POINTS   (NP),
    .ADDR_WIDTH (AW),
    .MAG_LATENCY(MagLatency)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [2*DW-1:0] ram [NP];
  wr_t             sb [$];
  int              exp_count   = 0;
  int              exp_rd_addr = 0;
  int              mag_starts  = 0;
  logic            prev_rd     = 1'b0;
  logic [AW-1:0]   prev_addr   = '0;
  int              exp_peak_bin = 0;
  logic [DW-1:0]   exp_peak_mag = '0;

  // Magnitude model of the external unit: Re + Im (the bench keeps both non-negative).
  function automatic logic [DW-1:0] mag_of(input logic [2*DW-1:0] c);
    return c[2*DW-1:DW] + c[DW-1:0];
  endfunction

  // FFT RAM: registered read, zero when no read was issued.
  always @(posedge clk) begin
    if (reset) bus.i_fft_rd_data <= '0;
    else       bus.i_fft_rd_data <= bus.o_fft_rd_en ? ram[bus.o_fft_rd_addr] : '0;
  end

  // Magnitude unit pipeline; deliberately not reset so stale results reach an idle DUT.
  logic [MagLatency-1:0] mv = '0;
  logic [DW-1:0]         mm [MagLatency];
  always @(posedge clk) begin
    mv    <= {mv[MagLatency-2:0], bus.o_mag_start};
    mm[0] <= mag_of(bus.o_mag_complex);
    for (int i = 1; i < MagLatency; i++) mm[i] <= mm[i-1];
  end
  assign bus.i_mag_valid     = mv[MagLatency-1];
  assign bus.i_mag_magnitude = mm[MagLatency-1];

  function automatic logic [255:0] all_outputs();
    return 256'({bus.o_busy, bus.o_done, bus.o_fft_rd_en, bus.o_fft_rd_addr, bus.o_mag_start,
                 bus.o_mag_complex, bus.o_spec_wr_en, bus.o_spec_wr_addr, bus.o_spec_wr_data,
                 bus.o_peak_bin, bus.o_peak_mag});
  endfunction

  // Advance to the next falling edge and service the read/operand/write scoreboard.
  task automatic observe_cycle();
    wr_t e;
    @(negedge clk);
    if (bus.o_mag_start === 1'b1 || prev_rd) begin
      vectors++;
      if (bus.o_mag_start !== prev_rd || bus.o_mag_complex !== ram[prev_addr]) begin
        miscompares++;
        $display("FAIL mag_operand: got start=%0b op=%h, want start=%0b op=%h",
                 bus.o_mag_start, bus.o_mag_complex, prev_rd, ram[prev_addr]);
      end
      if (bus.o_mag_start === 1'b1) mag_starts++;
    end
    prev_rd = (bus.o_fft_rd_en === 1'b1);
    if (bus.o_fft_rd_en === 1'b1) begin
      vectors++;
      if (exp_rd_addr >= exp_count || bus.o_fft_rd_addr !== AW'(exp_rd_addr)) begin
        miscompares++;
        $display("FAIL read_addr: got %0d, want %0d of %0d", bus.o_fft_rd_addr, exp_rd_addr,
                 exp_count);
      end
      prev_addr = AW'(exp_rd_addr);
      exp_rd_addr++;
    end
    if (bus.o_spec_wr_en === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL spec_write: got addr=%0d data=%0d, want no write",
                 bus.o_spec_wr_addr, bus.o_spec_wr_data);
      end else begin
        e = sb.pop_front();
        if (bus.o_spec_wr_addr !== e.addr || bus.o_spec_wr_data !== e.data) begin
          miscompares++;
          $display("FAIL spec_write: got addr=%0d data=%0d, want addr=%0d data=%0d",
                   bus.o_spec_wr_addr, bus.o_spec_wr_data, e.addr, e.data);
        end
      end
    end
  endtask

  // Queue the expected frame, then pulse start for one cycle (cycle T).
  task automatic start_frame(input logic half);
    int c;
    logic [DW-1:0] m;
    wr_t e;
    c = half ? NP / 2 : NP;
    sb.delete();
    exp_count    = c;
    exp_rd_addr  = 0;
    mag_starts   = 0;
    exp_peak_bin = 0;
    exp_peak_mag = '0;
    for (int i = 0; i < c; i++) begin
      m      = mag_of(ram[i]);
      e.addr = AW'(i);
      e.data = m;
      sb.push_back(e);
      if (m > exp_peak_mag) begin
        exp_peak_mag = m;
        exp_peak_bin = i;
      end
    end
    @(posedge clk);
    #1;
    bus.i_start         = 1'b1;
    bus.i_half_spectrum = half;
    observe_cycle();
    @(posedge clk);
    #1;
    bus.i_start         = 1'b0;
    bus.i_half_spectrum = 1'b0;
  endtask

  // Count cycles after start until done (-1 on timeout); also count busy cycles.
  task automatic wait_done(input int max, output int cyc, output int busy_cnt,
                           output logic busy_at_done);
    cyc          = -1;
    busy_cnt     = 0;
    busy_at_done = 1'b1;
    for (int k = 1; k <= max; k++) begin
      observe_cycle();
      if (bus.o_done === 1'b1) begin
        cyc          = k;
        busy_at_done = bus.o_busy;
        break;
      end
      if (bus.o_busy === 1'b1) busy_cnt++;
    end
  endtask

  task automatic load_ramp();
    for (int k = 0; k < NP; k++) ram[k] = {DW'(k), DW'(0)};
  endtask

  task automatic test_reset();
    repeat (3) observe_cycle();
    vectors++;
    if (all_outputs() !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, want 0", all_outputs());
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) observe_cycle();
    vectors++;
    if (all_outputs() !== '0) begin
      miscompares++;
      $display("FAIL idle_outputs: got %h, want 0", all_outputs());
    end
  endtask

  task automatic test_full_frame();
    int cyc, bc;
    logic bd;
    load_ramp();
    start_frame(1'b0);
    wait_done(60, cyc, bc, bd);
    vectors++;
    if (cyc != 13 || bc != 12 || bd !== 1'b0) begin
      miscompares++;
      $display("FAIL full_timing: got done=%0d busy=%0d busy_at_done=%b, want 13 12 0",
               cyc, bc, bd);
    end
    observe_cycle();
    vectors++;
    if (bus.o_done !== 1'b0 || sb.size() != 0 || mag_starts != 8 || exp_rd_addr != 8) begin
      miscompares++;
      $display("FAIL full_accounting: got done=%b left=%0d starts=%0d reads=%0d, want 0 0 8 8",
               bus.o_done, sb.size(), mag_starts, exp_rd_addr);
    end
    vectors++;
    if (bus.o_peak_bin !== AW'(exp_peak_bin) || bus.o_peak_mag !== exp_peak_mag ||
        exp_peak_bin != 7) begin
      miscompares++;
      $display("FAIL full_peak: got bin=%0d mag=%0d, want bin=%0d mag=%0d",
               bus.o_peak_bin, bus.o_peak_mag, exp_peak_bin, exp_peak_mag);
    end
    repeat (4) observe_cycle();
    vectors++;
    if (bus.o_peak_bin !== 3'd7 || bus.o_peak_mag !== 24'd7 || bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL peak_hold: got bin=%0d mag=%0d busy=%b, want 7 7 0",
               bus.o_peak_bin, bus.o_peak_mag, bus.o_busy);
    end
  endtask

  task automatic test_half_spectrum();
    int cyc, bc;
    logic bd;
    load_ramp();
    start_frame(1'b1);
    wait_done(60, cyc, bc, bd);
    vectors++;
    if (cyc != 9 || bc != 8 || bd !== 1'b0) begin
      miscompares++;
      $display("FAIL half_timing: got done=%0d busy=%0d busy_at_done=%b, want 9 8 0",
               cyc, bc, bd);
    end
    observe_cycle();
    vectors++;
    if (sb.size() != 0 || mag_starts != 4 || exp_rd_addr != 4 || bus.o_peak_bin !== 3'd3 ||
        bus.o_peak_mag !== exp_peak_mag) begin
      miscompares++;
      $display("FAIL half_result: got left=%0d starts=%0d reads=%0d bin=%0d mag=%0d, want 0 4 4 3 %0d",
               sb.size(), mag_starts, exp_rd_addr, bus.o_peak_bin, bus.o_peak_mag, exp_peak_mag);
    end
  endtask

  task automatic test_pause();
    int cyc, bc;
    logic bd;
    load_ramp();
    start_frame(1'b0);
    fork
      begin
        repeat (2) @(posedge clk);
        #1 bus.i_pause = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.i_pause = 1'b0;
      end
      wait_done(60, cyc, bc, bd);
    join
    vectors++;
    if (cyc != 16 || bc != 15 || bd !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_timing: got done=%0d busy=%0d busy_at_done=%b, want 16 15 0",
               cyc, bc, bd);
    end
    observe_cycle();
    vectors++;
    if (sb.size() != 0 || mag_starts != 8 || exp_rd_addr != 8) begin
      miscompares++;
      $display("FAIL pause_accounting: got left=%0d starts=%0d reads=%0d, want 0 8 8",
               sb.size(), mag_starts, exp_rd_addr);
    end
  endtask

  task automatic test_peak_tie_and_clear();
    int cyc, bc;
    logic bd;
    int mags [NP] = '{5, 9, 9, 2, 1, 0, 3, 4};
    for (int k = 0; k < NP; k++) ram[k] = {DW'(mags[k]), DW'(0)};
    start_frame(1'b0);
    wait_done(60, cyc, bc, bd);
    observe_cycle();
    vectors++;
    if (cyc != 13 || bus.o_peak_bin !== 3'd1 || bus.o_peak_mag !== 24'd9 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL peak_tie: got done=%0d bin=%0d mag=%0d left=%0d, want 13 1 9 0",
               cyc, bus.o_peak_bin, bus.o_peak_mag, sb.size());
    end
    for (int k = 0; k < NP; k++) ram[k] = '0;
    start_frame(1'b0);
    wait_done(60, cyc, bc, bd);
    observe_cycle();
    vectors++;
    if (cyc != 13 || bus.o_peak_bin !== 3'd0 || bus.o_peak_mag !== 24'd0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL peak_clear: got done=%0d bin=%0d mag=%0d left=%0d, want 13 0 0 0",
               cyc, bus.o_peak_bin, bus.o_peak_mag, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int first = -1;
    load_ramp();
    start_frame(1'b0);
    for (int k = 1; k <= 30; k++) begin
      observe_cycle();
      if (bus.o_done === 1'b1) begin
        dones++;
        if (first < 0) first = k;
      end
      if (k < 30) begin
        @(posedge clk);
        #1;
        bus.i_start = (k == 2);  // lands in cycle T+3, mid-read
      end
    end
    bus.i_start = 1'b0;
    vectors++;
    if (dones != 1 || first != 13 || exp_rd_addr != 8 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL start_while_busy: got dones=%0d first=%0d reads=%0d left=%0d, want 1 13 8 0",
               dones, first, exp_rd_addr, sb.size());
    end
  endtask

  task automatic test_mid_reset();
    int dones = 0;
    int cyc, bc;
    logic bd;
    load_ramp();
    start_frame(1'b0);
    for (int k = 1; k <= 9; k++) observe_cycle();
    @(posedge clk);
    #1;
    reset = 1'b1;
    observe_cycle();  // cycle T+10: still draining
    vectors++;
    if (bus.o_busy !== 1'b1 || bus.o_fft_rd_en !== 1'b0 || bus.o_done !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_state: got busy=%b rd_en=%b done=%b, want 1 0 0",
               bus.o_busy, bus.o_fft_rd_en, bus.o_done);
    end
    sb.delete();
    exp_count = 0;
    observe_cycle();  // cycle T+11: reset has taken effect
    vectors++;
    if (all_outputs() !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got %h, want 0", all_outputs());
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      observe_cycle();
      if (bus.o_done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0 || bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL no_done_after_reset: got dones=%0d busy=%b, want 0 0", dones, bus.o_busy);
    end
    ram[2] = {DW'(20), DW'(3)};
    start_frame(1'b0);
    wait_done(60, cyc, bc, bd);
    observe_cycle();
    vectors++;
    if (cyc != 13 || sb.size() != 0 || bus.o_peak_bin !== 3'd2 || bus.o_peak_mag !== 24'd23) begin
      miscompares++;
      $display("FAIL restart: got done=%0d left=%0d bin=%0d mag=%0d, want 13 0 2 23",
               cyc, sb.size(), bus.o_peak_bin, bus.o_peak_mag);
    end
  endtask

  initial begin
    bus.i_start         = 1'b0;
    bus.i_half_spectrum = 1'b0;
    bus.i_pause         = 1'b0;
    load_ramp();
    test_reset();
    test_full_frame();
    test_half_spectrum();
    test_pause();
    test_peak_tie_and_clear();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
